// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Contents: RISC-V load/store funct3 encodings, the LSU FSM state
// encodings and the state type. The decoder uses the same constants.
package lsu_pkg;

  // funct3 encodings for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM state encodings
  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t ST_IDLE  = 2'd0;
  localparam lsu_state_t ST_WRITE = 2'd1;
  localparam lsu_state_t ST_RESP  = 2'd2;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   word       in  32  current memory word (old word for stores)
//   addr_lo    in  2   byte offset within the word
//   size       in  3   funct3 of the access
//   we         in  1   1 = store, 0 = load
//   wd         in  32  store data (byte/half taken from the low bits)
//   load_val   out 32  extracted and extended load value
//   store_word out 32  word with the store data merged in
//   misaligned out 1   half on an odd address or word not on a word boundary
//   illegal    out 1   funct3 not valid for this access direction
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] load_val,
  output logic [31:0] store_word,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Move the addressed byte to the bottom; the half lane only depends on bit 1.
  assign shifted  = word >> {addr_lo, 3'b000};
  assign byte_val = shifted[7:0];
  assign half_val = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_val = word;
    case (size)
      F3_B:    load_val = {{24{byte_val[7]}}, byte_val};
      F3_BU:   load_val = {24'd0, byte_val};
      F3_H:    load_val = {{16{half_val[15]}}, half_val};
      F3_HU:   load_val = {16'd0, half_val};
      default: load_val = word;
    endcase
  end

  always_comb begin
    store_word = word;
    case (size)
      F3_B: begin
        case (addr_lo)
          2'd0:    store_word = {word[31:8], wd[7:0]};
          2'd1:    store_word = {word[31:16], wd[7:0], word[7:0]};
          2'd2:    store_word = {word[31:24], wd[7:0], word[15:0]};
          default: store_word = {wd[7:0], word[23:0]};
        endcase
      end
      F3_H:    store_word = addr_lo[1] ? {wd[15:0], word[15:0]} : {word[31:16], wd[15:0]};
      F3_W:    store_word = wd;
      default: store_word = word;
    endcase
  end

  always_comb begin
    illegal = 1'b1;
    case (size)
      F3_B, F3_H, F3_W: illegal = 1'b0;
      F3_BU, F3_HU:     illegal = we;   // unsigned forms exist only for loads
      default:          illegal = 1'b1;
    endcase
  end

  // size[1:0]==01 covers both LH/SH and LHU
  assign misaligned = ((size[1:0] == 2'b01) && addr_lo[0]) ||
                      ((size == F3_W) && (addr_lo != 2'b00));

endmodule

// File: rtl/lsu.sv
// Load/store unit between the execute stage and the word-wide data memory.
// One access at a time; sub-word stores are done as read-modify-write.
// Handshake: a request is taken on a rising edge where req_i && ready_o;
// ready_o is high only in IDLE and the core holds req_i until then.
// rvalid_o is a one-cycle completion pulse that cannot be stalled;
// rdata_o and err_o are meaningful while rvalid_o is high.
// Ports:
//   clk_i, rst_n_i                 clock, async active-low reset
//   req_i, we_i, size_i, addr_i, wd_i   request from the core
//   ready_o                        request can be accepted this cycle
//   rvalid_o, rdata_o, err_o       completion pulse, load data, error flag
//   mem_addr_o, mem_wd_o, mem_we_o word address / data / write enable to dm
//   mem_rd_i                       combinational read data from dm
//   state_o                        current FSM state (debug observation)
module lsu
  import lsu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wd_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  output logic        mem_we_o,
  input  logic [31:0] mem_rd_i,
  output lsu_state_t  state_o
);

  lsu_state_t  state;
  logic [29:0] word_addr;
  logic [31:0] load_val;
  logic [31:0] store_word;
  logic        misaligned;
  logic        illegal;

  // The read port is addressed from addr_i while IDLE, so the old word
  // and load data are available combinationally at the accept edge.
  lsu_align u_align (
    .word       (mem_rd_i),
    .addr_lo    (addr_i[1:0]),
    .size       (size_i),
    .we         (we_i),
    .wd         (wd_i),
    .load_val   (load_val),
    .store_word (store_word),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  assign ready_o    = (state == ST_IDLE);
  assign rvalid_o   = (state == ST_RESP);
  // Decoded from state so an async reset drops the write enable at once.
  assign mem_we_o   = (state == ST_WRITE);
  assign mem_addr_o = (state == ST_IDLE) ? {addr_i[31:2], 2'b00} : {word_addr, 2'b00};
  assign state_o    = state;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      word_addr <= '0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      mem_wd_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            word_addr <= addr_i[31:2];
            if (illegal || misaligned) begin
              err_o   <= 1'b1;
              rdata_o <= '0;
              state   <= ST_RESP;
            end else if (!we_i) begin
              err_o   <= 1'b0;
              rdata_o <= load_val;
              state   <= ST_RESP;
            end else begin
              err_o    <= 1'b0;
              rdata_o  <= '0;
              mem_wd_o <= store_word;
              state    <= ST_WRITE;
            end
          end
        end
        ST_WRITE: state <= ST_RESP;
        ST_RESP:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
